// File: rtl/risc_controller.sv
// risc_controller: control unit for the 16-bit datapath.
// Holds the instruction register, decodes its fields and sequences a Moore FSM
// whose state alone drives every datapath control strobe.
// Optional feature macro: RISC_CTRL_ILLEGAL_TRAP_EN. When defined, an
// unsupported instruction parks the FSM in HALT with the extra 'illegal'
// output high until reset; when undefined, it simply returns to WAIT.
module risc_controller #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [DATA_W-1:0] in,
    output logic              w,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic [1:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic              loadc,
    output logic              loads,
    output logic              write,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic              illegal
`endif
);

    // Writeback source encodings for vsel.
    localparam logic [1:0] VSEL_C      = 2'd0;
    localparam logic [1:0] VSEL_SXIMM8 = 2'd2;

    // Opcode / op encodings of the supported instruction set.
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WRITE_REG,
        S_HALT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] ir;

    // Instruction fields.
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    // Instruction class flags.
    logic is_movi;
    logic is_mov;
    logic is_alu;
    logic is_cmp;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_movi = (opcode == OPC_MOV) && (op == OP_MOVI);
    assign is_mov  = (opcode == OPC_MOV) && (op == OP_MOVR);
    assign is_alu  = (opcode == OPC_ALU);
    assign is_cmp  = is_alu && (op == OP_CMP);

    // Immediates are pure functions of the IR, valid in every state.
    assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

    // Instruction register: only loadable while idle so it stays stable mid-instruction.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            ir <= '0;
        end else if (load && (state == S_WAIT)) begin
            ir <= in;
        end
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore control outputs, all derived from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        w          = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        vsel       = VSEL_C;
        loada      = 1'b0;
        loadb      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        shift      = 2'b00;
        ALUop      = 2'b00;
        loadc      = 1'b0;
        loads      = 1'b0;
        write      = 1'b0;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_movi) begin
                    next_state = S_WRITE_IMM;
                end else if (is_mov) begin
                    // MOV has no A operand: it goes straight to fetching Rm.
                    next_state = S_GETB;
                end else if (is_alu) begin
                    next_state = S_GETA;
                end else begin
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
                    next_state = S_HALT;
`else
                    next_state = S_WAIT;
`endif
                end
            end

            S_WRITE_IMM: begin
                writenum   = rn;
                vsel       = VSEL_SXIMM8;
                write      = 1'b1;
                next_state = S_WAIT;
            end

            S_GETA: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GETB;
            end

            S_GETB: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_EXEC;
            end

            S_EXEC: begin
                shift = sh;
                if (is_mov) begin
                    // Zero on the A side turns the adder into a pass-through of shifted B.
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else begin
                    asel  = 1'b0;
                    ALUop = op;
                end
                if (is_cmp) begin
                    // CMP only updates status; the register file is left untouched.
                    loads      = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    loadc      = 1'b1;
                    next_state = S_WRITE_REG;
                end
            end

            S_WRITE_REG: begin
                writenum   = rd;
                vsel       = VSEL_C;
                write      = 1'b1;
                next_state = S_WAIT;
            end

`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
            S_HALT: begin
                // Trapped: everything quiet, only reset leaves this state.
                illegal    = 1'b1;
                next_state = S_HALT;
            end
`endif

            default: begin
                next_state = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench for risc_controller: the stimulus process drives one cycle at
// a time and queues the hand-computed control vector expected after that edge;
// an independent monitor pops and compares on every falling edge.
module tb_risc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic        load = 1'b0;
    logic [15:0] in = 16'h0000;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic        write;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic        illegal;

    always #5 clk = ~clk;

    risc_controller #(.DATA_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal  (illegal)
`endif
    );

`ifndef RISC_CTRL_ILLEGAL_TRAP_EN
    assign illegal = 1'b0;
`endif

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  vsel;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        loadc;
        logic        loads;
        logic        write;
        logic        illegal;
        logic [15:0] sximm5;
        logic [15:0] sximm8;
    } ctl_t;

    typedef struct {
        string name;
        ctl_t  v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Build an expected vector; bsel and illegal are always 0 here.
    function automatic ctl_t c(input logic w_e, input logic [2:0] rn_e, input logic [2:0] wn_e,
                               input logic [1:0] vs_e, input logic la_e, input logic lb_e,
                               input logic as_e, input logic [1:0] sh_e, input logic [1:0] op_e,
                               input logic lc_e, input logic ls_e, input logic wr_e,
                               input logic [15:0] s5_e, input logic [15:0] s8_e);
        ctl_t r;
        r          = '0;
        r.w        = w_e;
        r.readnum  = rn_e;
        r.writenum = wn_e;
        r.vsel     = vs_e;
        r.loada    = la_e;
        r.loadb    = lb_e;
        r.asel     = as_e;
        r.shift    = sh_e;
        r.aluop    = op_e;
        r.loadc    = lc_e;
        r.loads    = ls_e;
        r.write    = wr_e;
        r.sximm5   = s5_e;
        r.sximm8   = s8_e;
        return r;
    endfunction

    // Idle in WAIT with the given immediates.
    function automatic ctl_t wt(input logic [15:0] s5_e, input logic [15:0] s8_e);
        return c(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s5_e, s8_e);
    endfunction

    // DECODE: no strobes, w low.
    function automatic ctl_t dc(input logic [15:0] s5_e, input logic [15:0] s8_e);
        return c(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, s5_e, s8_e);
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input string nm, input logic r, input logic ld, input logic st,
                        input logic [15:0] d, input ctl_t e);
        exp_t x;
        @(negedge clk);
        #1;
        reset = r;
        load  = ld;
        s     = st;
        in    = d;
        x.name = nm;
        x.v    = e;
        sb.push_back(x);
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    initial begin
        exp_t x;
        ctl_t act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                act          = '0;
                act.w        = w;
                act.readnum  = readnum;
                act.writenum = writenum;
                act.vsel     = vsel;
                act.loada    = loada;
                act.loadb    = loadb;
                act.asel     = asel;
                act.bsel     = bsel;
                act.shift    = shift;
                act.aluop    = ALUop;
                act.loadc    = loadc;
                act.loads    = loads;
                act.write    = write;
                act.illegal  = illegal;
                act.sximm5   = sximm5;
                act.sximm8   = sximm8;
                n_checks++;
                if (act === x.v) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %h expected %h", x.name, act, x.v);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctl_t halt_v;
        halt_v         = '0;
        halt_v.illegal = 1'b1;

        // Reset, including priority over load and s.
        step("rst0",        1, 0, 0, 16'h0000, wt(16'h0000, 16'h0000));
        step("rst_prio",    1, 1, 1, 16'hD007, wt(16'h0000, 16'h0000));

        // MOVI R0,#7: done two edges after s.
        step("movi0_ld",    0, 1, 0, 16'hD007, wt(16'h0007, 16'h0007));
        step("movi0_dec",   0, 0, 1, 16'h0000, dc(16'h0007, 16'h0007));
        step("movi0_wimm",  0, 0, 0, 16'h0000, c(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0007, 16'h0007));
        step("movi0_done",  0, 0, 0, 16'h0000, wt(16'h0007, 16'h0007));

        // MOVI R1,#-1.
        step("movi1_ld",    0, 1, 0, 16'hD1FF, wt(16'hFFFF, 16'hFFFF));
        step("movi1_dec",   0, 0, 1, 16'h0000, dc(16'hFFFF, 16'hFFFF));
        step("movi1_wimm",  0, 0, 0, 16'h0000, c(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF));
        step("movi1_done",  0, 0, 0, 16'h0000, wt(16'hFFFF, 16'hFFFF));

        // ADD R2,R1,R0,LSL#1 with a stray load during GETA and s during EXEC.
        step("add_ld",      0, 1, 0, 16'hA148, wt(16'h0008, 16'h0048));
        step("add_dec",     0, 0, 1, 16'h0000, dc(16'h0008, 16'h0048));
        step("add_geta",    0, 0, 0, 16'h0000, c(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 16'h0048));
        step("add_getb",    0, 1, 0, 16'hD0FF, c(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0008, 16'h0048));
        step("add_exec",    0, 0, 0, 16'h0000, c(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'h0008, 16'h0048));
        step("add_wreg",    0, 0, 1, 16'h0000, c(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 16'h0048));
        step("add_done",    0, 0, 0, 16'h0000, wt(16'h0008, 16'h0048));

        // CMP R1,R0: status only, done after four edges.
        step("cmp_ld",      0, 1, 0, 16'hA900, wt(16'h0000, 16'h0000));
        step("cmp_dec",     0, 0, 1, 16'h0000, dc(16'h0000, 16'h0000));
        step("cmp_geta",    0, 0, 0, 16'h0000, c(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
        step("cmp_getb",    0, 0, 0, 16'h0000, c(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000));
        step("cmp_exec",    0, 0, 0, 16'h0000, c(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0000, 16'h0000));
        step("cmp_done",    0, 0, 0, 16'h0000, wt(16'h0000, 16'h0000));

        // MOV R1,R0: skips GETA, A side forced to zero.
        step("mov_ld",      0, 1, 0, 16'hC020, wt(16'h0000, 16'h0020));
        step("mov_dec",     0, 0, 1, 16'h0000, dc(16'h0000, 16'h0020));
        step("mov_getb",    0, 0, 0, 16'h0000, c(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0020));
        step("mov_exec",    0, 0, 0, 16'h0000, c(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 16'h0000, 16'h0020));
        step("mov_wreg",    0, 0, 0, 16'h0000, c(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0020));
        step("mov_done",    0, 0, 0, 16'h0000, wt(16'h0000, 16'h0020));

        // s held high: one WAIT cycle, then the same MOVI runs again.
        step("rep_ld",      0, 1, 0, 16'hD007, wt(16'h0007, 16'h0007));
        step("rep_dec1",    0, 0, 1, 16'h0000, dc(16'h0007, 16'h0007));
        step("rep_wimm1",   0, 0, 1, 16'h0000, c(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0007, 16'h0007));
        step("rep_wait",    0, 0, 1, 16'h0000, wt(16'h0007, 16'h0007));
        step("rep_dec2",    0, 0, 1, 16'h0000, dc(16'h0007, 16'h0007));
        step("rep_wimm2",   0, 0, 0, 16'h0000, c(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0007, 16'h0007));
        step("rep_done",    0, 0, 0, 16'h0000, wt(16'h0007, 16'h0007));

        // Reset while in GETB: back to WAIT with IR cleared, no later write.
        step("abort_ld",    0, 1, 0, 16'hA148, wt(16'h0008, 16'h0048));
        step("abort_dec",   0, 0, 1, 16'h0000, dc(16'h0008, 16'h0048));
        step("abort_geta",  0, 0, 0, 16'h0000, c(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 16'h0048));
        step("abort_getb",  0, 0, 0, 16'h0000, c(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0008, 16'h0048));
        step("abort_rst",   1, 0, 0, 16'h0000, wt(16'h0000, 16'h0000));
        step("abort_idle1", 0, 0, 0, 16'h0000, wt(16'h0000, 16'h0000));
        step("abort_idle2", 0, 0, 0, 16'h0000, wt(16'h0000, 16'h0000));

        // Unsupported instruction.
        step("ill_ld",      0, 1, 0, 16'hE000, wt(16'h0000, 16'h0000));
        step("ill_dec",     0, 0, 1, 16'h0000, dc(16'h0000, 16'h0000));
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
        step("ill_halt1",   0, 0, 1, 16'h0000, halt_v);
        step("ill_halt2",   0, 1, 1, 16'hD007, halt_v);
        step("ill_halt3",   0, 0, 0, 16'h0000, halt_v);
        step("ill_halt4",   0, 0, 0, 16'h0000, halt_v);
        step("ill_rst",     1, 0, 0, 16'h0000, wt(16'h0000, 16'h0000));
`else
        step("ill_wait1",   0, 0, 0, 16'h0000, wt(16'h0000, 16'h0000));
        step("ill_wait2",   0, 0, 0, 16'h0000, wt(16'h0000, 16'h0000));
`endif
        // IR still loadable after the unsupported instruction.
        step("post_ld",     0, 1, 0, 16'hD1FF, wt(16'hFFFF, 16'hFFFF));

        // Let the monitor consume the last expectation, then confirm the queue drained.
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
